// File: rtl/ppd_poly_mac.sv
// Polyphase decimate-by-4 FIR MAC: one 4-phase frame in, one filtered sample out.
// Phases are folded into a time-shared 4-tap MAC, one phase per cycle.
module ppd_poly_mac #(
    parameter int              DW   = 11,
    parameter int              CW   = 12,
    parameter logic [16*CW-1:0] COEF = {CW'(16), CW'(15), CW'(14), CW'(13),
                                        CW'(12), CW'(11), CW'(10), CW'(9),
                                        CW'(8),  CW'(7),  CW'(6),  CW'(5),
                                        CW'(4),  CW'(3),  CW'(2),  CW'(1)},
    parameter int              OW   = DW + CW + 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 phase_en_i,
    input  logic signed [DW-1:0] signal_phase1_i,
    input  logic signed [DW-1:0] signal_phase2_i,
    input  logic signed [DW-1:0] signal_phase3_i,
    input  logic signed [DW-1:0] signal_phase4_i,
    output logic signed [OW-1:0] y_o,
    output logic                 valid_o,
    output logic                 overrun_o
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 ph_cnt_q, ph_cnt_d;
    logic signed [OW-1:0]       acc_q, acc_d;
    logic signed [OW-1:0]       y_q, y_d;
    logic                       valid_q, valid_d;
    logic                       ovr_q, ovr_d;
    logic [3:0][3:0][DW-1:0]    line_q, line_d;
    logic [3:0][DW-1:0]         phase_in;
    logic                       shift;

    logic signed [CW-1:0]       coef_a [16];
    logic signed [OW-1:0]       prod [4];
    logic signed [OW-1:0]       part_sum;

    assign phase_in = {signal_phase4_i, signal_phase3_i, signal_phase2_i, signal_phase1_i};

    for (genvar n = 0; n < 16; n++) begin : g_coef
        assign coef_a[n] = COEF[n*CW +: CW];
    end

    // Tap k of the active phase uses h[4k+ph_cnt] against that phase's k-th oldest sample.
    for (genvar k = 0; k < 4; k++) begin : g_tap
        logic signed [DW-1:0] x_sel;
        logic signed [CW-1:0] c_sel;
        assign x_sel   = line_q[ph_cnt_q][k];
        assign c_sel   = coef_a[{2'(k), ph_cnt_q}];
        assign prod[k] = OW'(x_sel) * OW'(c_sel);
    end

    assign part_sum = prod[0] + prod[1] + prod[2] + prod[3];

    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        acc_d    = acc_q;
        y_d      = y_q;
        valid_d  = 1'b0;
        ovr_d    = ovr_q;
        shift    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (phase_en_i) begin
                    shift    = 1'b1;
                    state_d  = CALC;
                    ph_cnt_d = 2'd0;
                    acc_d    = '0;
                end
            end
            CALC: begin
                if (ph_cnt_q == 2'd3) begin
                    // Finishing frame reads pre-shift lines; a new frame may shift on this same edge.
                    y_d      = acc_q + part_sum;
                    valid_d  = 1'b1;
                    acc_d    = '0;
                    ph_cnt_d = 2'd0;
                    if (phase_en_i) shift = 1'b1;
                    else            state_d = IDLE;
                end else begin
                    acc_d    = acc_q + part_sum;
                    ph_cnt_d = ph_cnt_q + 2'd1;
                    if (phase_en_i) ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        line_d = line_q;
        if (shift) begin
            for (int p = 0; p < 4; p++) begin
                line_d[p] = {line_q[p][2:0], phase_in[p]};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ph_cnt_q <= 2'd0;
            acc_q    <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            ph_cnt_q <= ph_cnt_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            line_q   <= line_d;
        end
    end

    assign y_o       = y_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_ppd_poly_mac.sv
// Directed bench for ppd_poly_mac: impulses, extremes, streaming, overrun and reset abort.
module tb_ppd_poly_mac;

    localparam int DW = 11;
    localparam int CW = 12;
    localparam int OW = DW + CW + 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic signed [DW-1:0] p1, p2, p3, p4;
    logic signed [OW-1:0] y, y2;
    logic                 vld, vld2, ovr, ovr2;

    int nchk  = 0;
    int nfail = 0;

    longint hv [16];
    longint hist [4][4];
    longint exp_pend;
    bit     have_pend;
    longint obs_q [$];

    always #5 clk = ~clk;

    ppd_poly_mac #(.DW(DW), .CW(CW)) dut (
        .clk_i(clk), .rst_i(rst), .phase_en_i(en),
        .signal_phase1_i(p1), .signal_phase2_i(p2),
        .signal_phase3_i(p3), .signal_phase4_i(p4),
        .y_o(y), .valid_o(vld), .overrun_o(ovr)
    );

    ppd_poly_mac #(.DW(DW), .CW(CW), .COEF({16{12'h800}})) dut_neg (
        .clk_i(clk), .rst_i(rst), .phase_en_i(en),
        .signal_phase1_i(p1), .signal_phase2_i(p2),
        .signal_phase3_i(p3), .signal_phase4_i(p4),
        .y_o(y2), .valid_o(vld2), .overrun_o(ovr2)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint golden();
        longint s = 0;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++)
                s += hv[4*k+p] * hist[p][k];
        return s;
    endfunction

    task automatic clear_model();
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++)
                hist[p][k] = 0;
        have_pend = 0;
        obs_q.delete();
    endtask

    task automatic garble();
        p1 = DW'($urandom); p2 = DW'($urandom);
        p3 = DW'($urandom); p4 = DW'($urandom);
    endtask

    // Drive one frame at cycle T, check previous frame's result at T+1,
    // optionally inject an extra strobe at T+drop_at, return at T+4.
    task automatic push(input int x1, input int x2, input int x3, input int x4, input int drop_at);
        longint xin [4];
        xin = '{longint'(x1), longint'(x2), longint'(x3), longint'(x4)};
        en = 1'b1;
        p1 = DW'(x1); p2 = DW'(x2); p3 = DW'(x3); p4 = DW'(x4);
        step();
        en = 1'b0;
        garble();
        if (have_pend) begin
            chk("valid_pulse", longint'(vld), 1);
            chk("y_stream", longint'(y), exp_pend);
            obs_q.push_back(longint'(y));
        end else begin
            chk("valid_early", longint'(vld), 0);
        end
        for (int p = 0; p < 4; p++) begin
            for (int k = 3; k > 0; k--) hist[p][k] = hist[p][k-1];
            hist[p][0] = xin[p];
        end
        exp_pend  = golden();
        have_pend = 1;
        for (int c = 1; c <= 3; c++) begin
            if (c == drop_at) en = 1'b1;
            step();
            en = 1'b0;
            chk("valid_gap", longint'(vld), 0);
        end
    endtask

    task automatic flush();
        step();
        chk("valid_last", longint'(vld), 1);
        chk("y_last", longint'(y), exp_pend);
        obs_q.push_back(longint'(y));
        have_pend = 0;
        step();
        chk("valid_single", longint'(vld), 0);
    endtask

    task automatic chk_seq(input string tag, input longint e0, input longint e1,
                           input longint e2, input longint e3, input longint e4);
        longint e [5];
        e = '{e0, e1, e2, e3, e4};
        chk({tag, "_count"}, longint'(obs_q.size()), 5);
        for (int i = 0; i < 5; i++)
            chk(tag, (i < obs_q.size()) ? obs_q[i] : -999999, e[i]);
    endtask

    task automatic impulse(input int ph);
        push(ph == 1 ? 1 : 0, ph == 2 ? 1 : 0, ph == 3 ? 1 : 0, ph == 4 ? 1 : 0, 0);
        for (int i = 0; i < 4; i++) push(0, 0, 0, 0, 0);
        flush();
    endtask

    initial begin
        for (int n = 0; n < 16; n++) hv[n] = n + 1;
        clear_model();
        rst = 1'b1; en = 1'b0;
        p1 = '0; p2 = '0; p3 = '0; p4 = '0;
        step(); step();
        chk("rst_y", longint'(y), 0);
        chk("rst_valid", longint'(vld), 0);
        chk("rst_overrun", longint'(ovr), 0);
        chk("rst_y_neg", longint'(y2), 0);
        rst = 1'b0;
        step();

        // Impulse on phase 1 walks h[0],h[4],h[8],h[12]
        impulse(1);
        chk_seq("imp_ph1", 1, 5, 9, 13, 0);
        obs_q.delete();

        // Impulse on phase 4 walks h[3],h[7],h[11],h[15]; flush checks valid at T+5
        impulse(4);
        chk_seq("imp_ph4", 4, 8, 12, 16, 0);
        obs_q.delete();

        // Extremes through the all -2048 coefficient instance
        for (int i = 0; i < 4; i++) push(-1024, -1024, -1024, -1024, 0);
        flush();
        chk("ext_neg_neg", longint'(y2), 33554432);
        for (int i = 0; i < 4; i++) push(1023, 1023, 1023, 1023, 0);
        flush();
        chk("ext_pos_neg", longint'(y2), -33521664);
        chk("ext_overrun", longint'(ovr2), 0);
        obs_q.delete();

        // Back-to-back random frames
        for (int i = 0; i < 8; i++)
            push(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
                 int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024, 0);
        flush();
        chk("stream_no_overrun", longint'(ovr), 0);

        // Strobe two cycles after an accepted one is dropped
        push(100, -200, 300, -400, 2);
        chk("overrun_set", longint'(ovr), 1);
        for (int i = 0; i < 3; i++)
            push(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
                 int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024, 0);
        flush();
        chk("overrun_sticky", longint'(ovr), 1);

        // Reset while CALC is at ph_cnt=1
        en = 1'b1;
        p1 = 11'sd7; p2 = 11'sd7; p3 = 11'sd7; p4 = 11'sd7;
        step();
        en = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_y", longint'(y), 0);
        chk("midrst_valid", longint'(vld), 0);
        chk("midrst_overrun", longint'(ovr), 0);
        step(); step(); step();
        chk("midrst_no_valid", longint'(vld), 0);
        rst = 1'b0;
        clear_model();
        step();
        impulse(1);
        chk_seq("post_rst_imp", 1, 5, 9, 13, 0);
        chk("post_rst_overrun", longint'(ovr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
